tlb_refill_ctrl: RTL and testbench
==================================

// Module: tlb_refill_ctrl
// PURPOSE
//   Upstream refill controller for the 8-entry TLB attribute path.
//   On a lookup miss it captures the missing VPN and chooses a victim way: the
//   lowest invalid way first, otherwise the tree-PLRU victim.
//   It runs the PTW request/response handshake and holds r_refill_waddr stable
//   until the walk ends. The attribute-update stage consumes r_refill_waddr.
//   It drives refill_we, which is the write strobe for the valid, u, sw, sx, sr,
//   xr, cash and dirty arrays.
// PARAMETERS
//   ENTRIES  8   TLB ways (fixed at 8; PLRU tree is 7 bits)
//   WAY_W    3   log2(ENTRIES)
//   VPN_W    27  virtual page number width (Sv39)
// PORTS
//   clk                 in   1      clock, all state on rising edge
//   rst_n               in   1      asynchronous reset, active-low
//   io_req_valid        in   1      lookup request this cycle
//   io_req_bits_vpn     in   VPN_W  VPN of lookup
//   io_req_miss         in   1      lookup missed (qualified by io_req_valid)
//   io_req_ready        out  1      controller can accept a miss (state==READY)
//   io_hit_valid        in   1      a lookup hit a way (PLRU touch)
//   io_hit_way          in   WAY_W  way that hit
//   valid               in   8      current TLB valid array
//   io_sfence           in   1      flush request; current walk result is discarded
//   io_ptw_req_valid    out  1      PTW request (state==REQUEST)
//   io_ptw_req_ready    in   1      PTW accepts request
//   io_ptw_req_bits_vpn out  VPN_W  = r_refill_tag
//   io_ptw_resp_valid   in   1      PTW response (1-cycle pulse)
//   r_refill_waddr      out  WAY_W  victim way, registered
//   r_refill_tag        out  VPN_W  missing VPN, registered
//   refill_we           out  1      = io_ptw_resp_valid & (state==WAIT)
//   state_o             out  2      debug: current state
// BEHAVIOUR
//   States (2b): READY=0, REQUEST=1, WAIT=2, WAIT_INV=3.
//   Reset (async, rst_n=0): state=READY; plru=7'b0; r_refill_waddr=0;
//     r_refill_tag=0; io_ptw_req_valid=0; refill_we=0; io_req_ready=1.
//   READY: io_req_valid & io_req_miss & ~io_sfence -> REQUEST.
//     In the same edge, r_refill_tag<=vpn.
//     In the same edge, r_refill_waddr<=victim, sampled from valid/plru in that cycle.
//   REQUEST: io_ptw_req_valid=1; vpn stable.
//     ptw_req_ready & ~sfence -> WAIT.
//     ptw_req_ready & sfence -> WAIT_INV.
//     ~ptw_req_ready & sfence -> READY, no walk issued.
//   WAIT: resp_valid -> READY, and refill_we=1 in that cycle (combinational).
//     sfence & ~resp_valid -> WAIT_INV.
//     sfence & resp_valid -> READY, but refill_we is still asserted.
//   WAIT_INV: resp_valid -> READY, refill_we=0 (result dropped).
//   resp_valid in READY/REQUEST is ignored (no strobe, no state change).
//   io_req_valid outside READY is ignored; the lookup stage must replay it.
//   r_refill_waddr/tag change only on the READY->REQUEST edge and hold through WAIT.
//   Victim: if valid!=8'hFF, choose the lowest index i with valid[i]==0.
//     Otherwise walk the PLRU tree.
//   PLRU tree: node n has children 2n+1 (left) and 2n+2 (right).
//     Nodes 3..6 select ways {0,1},{2,3},{4,5},{6,7}.
//     Walk: at node n go right iff plru[n]==1.
//   Touch way w: every node on the path to w is set to point away from w
//     (bit=1 if w lies in the left subtree, else 0).
//   Touch sources: refill_we touches r_refill_waddr; io_hit_valid touches io_hit_way.
//     If both occur in the same cycle, the refill touch wins and the hit touch is dropped.
//   Reset mid-walk: the state returns to READY immediately.
//     A late PTW response after reset is ignored.
// TESTING
//   1 Reset, valid=8'h00, miss vpn=27'h123 -> next cycle state=REQUEST, waddr=0,
//     ptw_req_vpn=27'h123.
//   2 valid=8'hFF, plru=0, miss -> waddr=0; resp -> refill_we=1 for 1 cycle;
//     plru=7'b0001011; next full miss -> waddr=4.
//   3 REQUEST with ptw_req_ready=0 for 5 cycles -> req_valid held, vpn/waddr stable;
//     ready=1 -> WAIT.
//   4 WAIT, sfence pulse, then resp_valid -> state WAIT_INV then READY, refill_we
//     never 1.
//   5 Same cycle refill_we (way 2) and hit way 7 -> plru reflects only the way-2
//     touch.
//   6 rst_n low during WAIT, then resp_valid -> state=READY, refill_we=0, plru=0.

Source files
------------

// File: rtl/tlb_refill_ctrl_if.sv
// rtl/tlb_refill_ctrl_if.sv - PTW request/response handshake bundle for the TLB refill controller
//
// Purpose: groups the page-table-walker handshake between the refill
//   controller (master) and the PTW (slave).
// Signals:
//   io_ptw_req_valid     master->slave  walk request
//   io_ptw_req_ready     slave->master  PTW accepts the request
//   io_ptw_req_bits_vpn  master->slave  VPN to walk
//   io_ptw_resp_valid    slave->master  walk response (1-cycle pulse)
interface tlb_refill_ctrl_if #(
  parameter int VPN_W = 27
);
  logic             io_ptw_req_valid;
  logic             io_ptw_req_ready;
  logic [VPN_W-1:0] io_ptw_req_bits_vpn;
  logic             io_ptw_resp_valid;

  modport master (
    output io_ptw_req_valid,
    output io_ptw_req_bits_vpn,
    input  io_ptw_req_ready,
    input  io_ptw_resp_valid
  );

  modport slave (
    input  io_ptw_req_valid,
    input  io_ptw_req_bits_vpn,
    output io_ptw_req_ready,
    output io_ptw_resp_valid
  );
endinterface

// File: rtl/tlb_refill_ctrl.sv
// rtl/tlb_refill_ctrl.sv - TLB miss refill controller with invalid-first / tree-PLRU victim choice
//
// Purpose: on a lookup miss, captures the VPN and a victim way, runs the PTW
//   handshake, and strobes refill_we when the walk result is to be written.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   io_req_valid        lookup request this cycle
//   io_req_bits_vpn     VPN of the lookup
//   io_req_miss         lookup missed
//   io_req_ready        controller idle and able to take a miss
//   io_hit_valid        lookup hit (PLRU touch)
//   io_hit_way          way that hit
//   valid               TLB valid array
//   io_sfence           flush; discards the walk in flight
//   ptw                 PTW handshake (master side)
//   r_refill_waddr      registered victim way
//   r_refill_tag        registered missing VPN
//   refill_we           attribute-array write strobe
//   state_o             current state (debug)
module tlb_refill_ctrl #(
  parameter int ENTRIES = 8,
  parameter int WAY_W   = 3,
  parameter int VPN_W   = 27
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                io_req_valid,
  input  logic [VPN_W-1:0]    io_req_bits_vpn,
  input  logic                io_req_miss,
  output logic                io_req_ready,
  input  logic                io_hit_valid,
  input  logic [WAY_W-1:0]    io_hit_way,
  input  logic [ENTRIES-1:0]  valid,
  input  logic                io_sfence,
  tlb_refill_ctrl_if.master   ptw,
  output logic [WAY_W-1:0]    r_refill_waddr,
  output logic [VPN_W-1:0]    r_refill_tag,
  output logic                refill_we,
  output logic [1:0]          state_o
);

  typedef enum logic [1:0] {
    READY    = 2'd0,
    REQUEST  = 2'd1,
    WAIT     = 2'd2,
    WAIT_INV = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [6:0]       plru;
  logic [6:0]       plru_d;
  logic [WAY_W-1:0] victim;
  logic [WAY_W-1:0] plru_way;
  logic             accept_miss;

  // Each tree node on the path to w is pointed at the other subtree.
  function automatic logic [6:0] plru_touch(input logic [6:0] p, input logic [2:0] w);
    logic [6:0] r;
    r = p;
    r[0] = ~w[2];
    r[3'd1 + {2'b00, w[2]}] = ~w[1];
    r[3'd3 + {1'b0, w[2:1]}] = ~w[0];
    return r;
  endfunction

  assign accept_miss = (state_q == READY) && io_req_valid && io_req_miss && !io_sfence;

  // Tree walk: go right at a node whose bit is 1.
  always_comb begin
    plru_way    = '0;
    plru_way[2] = plru[0];
    plru_way[1] = plru[3'd1 + {2'b00, plru_way[2]}];
    plru_way[0] = plru[3'd3 + {1'b0, plru_way[2:1]}];
  end

  // Lowest invalid way wins; the PLRU choice applies only when all ways are valid.
  always_comb begin
    victim = plru_way;
    if (valid != {ENTRIES{1'b1}}) begin
      for (int i = ENTRIES - 1; i >= 0; i--) begin
        if (!valid[i]) victim = WAY_W'(i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      READY: begin
        if (accept_miss) state_d = REQUEST;
      end
      REQUEST: begin
        if (ptw.io_ptw_req_ready) state_d = io_sfence ? WAIT_INV : WAIT;
        else if (io_sfence)       state_d = READY;
      end
      WAIT: begin
        if (ptw.io_ptw_resp_valid) state_d = READY;
        else if (io_sfence)        state_d = WAIT_INV;
      end
      WAIT_INV: begin
        if (ptw.io_ptw_resp_valid) state_d = READY;
      end
      default: state_d = READY;
    endcase
  end

  // A flush that coincides with the response still commits the refill.
  assign refill_we = ptw.io_ptw_resp_valid && (state_q == WAIT);

  // Refill touch has priority; a simultaneous hit touch is dropped.
  always_comb begin
    plru_d = plru;
    if (refill_we)         plru_d = plru_touch(plru, r_refill_waddr);
    else if (io_hit_valid) plru_d = plru_touch(plru, io_hit_way);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= READY;
      plru           <= '0;
      r_refill_waddr <= '0;
      r_refill_tag   <= '0;
    end else begin
      state_q <= state_d;
      plru    <= plru_d;
      if (accept_miss) begin
        r_refill_waddr <= victim;
        r_refill_tag   <= io_req_bits_vpn;
      end
    end
  end

  assign io_req_ready            = (state_q == READY);
  assign ptw.io_ptw_req_valid    = (state_q == REQUEST);
  assign ptw.io_ptw_req_bits_vpn = r_refill_tag;
  assign state_o                 = state_q;

endmodule

// File: tb/tb_tlb_refill_ctrl.sv
// tb/tb_tlb_refill_ctrl.sv - directed self-checking bench for tlb_refill_ctrl
module tb_tlb_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        io_req_valid;
  logic [26:0] io_req_bits_vpn;
  logic        io_req_miss;
  logic        io_req_ready;
  logic        io_hit_valid;
  logic [2:0]  io_hit_way;
  logic [7:0]  valid;
  logic        io_sfence;
  logic [2:0]  r_refill_waddr;
  logic [26:0] r_refill_tag;
  logic        refill_we;
  logic [1:0]  state_o;

  int n_vec = 0;
  int n_err = 0;

  tlb_refill_ctrl_if #(.VPN_W(27)) ptw_if ();

  tlb_refill_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .io_req_valid    (io_req_valid),
    .io_req_bits_vpn (io_req_bits_vpn),
    .io_req_miss     (io_req_miss),
    .io_req_ready    (io_req_ready),
    .io_hit_valid    (io_hit_valid),
    .io_hit_way      (io_hit_way),
    .valid           (valid),
    .io_sfence       (io_sfence),
    .ptw             (ptw_if.master),
    .r_refill_waddr  (r_refill_waddr),
    .r_refill_tag    (r_refill_tag),
    .refill_we       (refill_we),
    .state_o         (state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic miss(input logic [26:0] v);
    io_req_valid    = 1'b1;
    io_req_miss     = 1'b1;
    io_req_bits_vpn = v;
    tick();
    io_req_valid    = 1'b0;
    io_req_miss     = 1'b0;
  endtask

  task automatic ptw_accept(input logic sf);
    ptw_if.io_ptw_req_ready = 1'b1;
    io_sfence               = sf;
    tick();
    ptw_if.io_ptw_req_ready = 1'b0;
    io_sfence               = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    io_req_valid = 1'b0; io_req_bits_vpn = '0; io_req_miss = 1'b0;
    io_hit_valid = 1'b0; io_hit_way = '0; valid = 8'h00; io_sfence = 1'b0;
    ptw_if.io_ptw_req_ready = 1'b0; ptw_if.io_ptw_resp_valid = 1'b0;
    tick(); tick();
    check("rst_state", state_o, 0);
    check("rst_req_ready", io_req_ready, 1);
    check("rst_ptw_valid", ptw_if.io_ptw_req_valid, 0);
    check("rst_refill_we", refill_we, 0);
    check("rst_waddr", r_refill_waddr, 0);
    check("rst_tag", r_refill_tag, 0);
    check("rst_plru", dut.plru, 0);
    rst_n = 1'b1;
    tick();

    // First miss with an empty TLB
    valid = 8'h00;
    miss(27'h123);
    check("t1_state", state_o, 1);
    check("t1_waddr", r_refill_waddr, 0);
    check("t1_ptw_vpn", ptw_if.io_ptw_req_bits_vpn, 27'h123);
    check("t1_ptw_valid", ptw_if.io_ptw_req_valid, 1);
    check("t1_req_ready", io_req_ready, 0);

    // PTW stalls for 5 cycles; a new lookup miss meanwhile must not be captured
    io_req_valid = 1'b1; io_req_miss = 1'b1; io_req_bits_vpn = 27'h555; valid = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_state", state_o, 1);
      check("t3_ptw_valid", ptw_if.io_ptw_req_valid, 1);
      check("t3_ptw_vpn", ptw_if.io_ptw_req_bits_vpn, 27'h123);
      check("t3_waddr", r_refill_waddr, 0);
    end
    io_req_valid = 1'b0; io_req_miss = 1'b0;
    ptw_accept(1'b0);
    check("t3_wait", state_o, 2);
    check("t3_ptw_valid_low", ptw_if.io_ptw_req_valid, 0);

    // Asynchronous reset mid-walk; the late response must be ignored
    rst_n = 1'b0;
    #1;
    check("t6_async_state", state_o, 0);
    tick();
    rst_n = 1'b1;
    ptw_if.io_ptw_resp_valid = 1'b1;
    #1;
    check("t6_late_we", refill_we, 0);
    tick();
    ptw_if.io_ptw_resp_valid = 1'b0;
    check("t6_state", state_o, 0);
    check("t6_plru", dut.plru, 0);
    check("t6_tag", r_refill_tag, 0);

    // Full TLB, PLRU victim from the all-zero tree
    valid = 8'hFF;
    miss(27'h4AB);
    check("t2_waddr0", r_refill_waddr, 0);
    check("t2_tag", r_refill_tag, 27'h4AB);
    ptw_accept(1'b0);
    ptw_if.io_ptw_resp_valid = 1'b1;
    #1;
    check("t2_we_high", refill_we, 1);
    tick();
    ptw_if.io_ptw_resp_valid = 1'b0;
    check("t2_we_low", refill_we, 0);
    check("t2_state", state_o, 0);
    check("t2_plru_a", dut.plru, 7'b0001011);
    miss(27'h7FFFFFF);
    check("t2_waddr4", r_refill_waddr, 4);
    check("t2_tag_max", r_refill_tag, 27'h7FFFFFF);
    ptw_accept(1'b0);
    ptw_if.io_ptw_resp_valid = 1'b1;
    tick();
    ptw_if.io_ptw_resp_valid = 1'b0;
    check("t2_plru_b", dut.plru, 7'b0101110);

    // Refill of way 2 and a hit on way 7 in the same cycle
    miss(27'h10);
    check("t5_waddr2", r_refill_waddr, 2);
    ptw_accept(1'b0);
    ptw_if.io_ptw_resp_valid = 1'b1;
    io_hit_valid = 1'b1; io_hit_way = 3'd7;
    #1;
    check("t5_we", refill_we, 1);
    tick();
    ptw_if.io_ptw_resp_valid = 1'b0;
    io_hit_valid = 1'b0;
    check("t5_plru", dut.plru, 7'b0111101);
    io_hit_valid = 1'b1; io_hit_way = 3'd7;
    tick();
    io_hit_valid = 1'b0;
    check("hit7_plru", dut.plru, 7'b0111000);

    // Flush during WAIT drops the result
    miss(27'h20);
    check("t4_waddr1", r_refill_waddr, 1);
    ptw_accept(1'b0);
    io_sfence = 1'b1;
    tick();
    io_sfence = 1'b0;
    check("t4_wait_inv", state_o, 3);
    ptw_if.io_ptw_resp_valid = 1'b1;
    #1;
    check("t4_we", refill_we, 0);
    tick();
    ptw_if.io_ptw_resp_valid = 1'b0;
    check("t4_state", state_o, 0);
    check("t4_plru", dut.plru, 7'b0111000);

    // Lowest invalid way; flush together with PTW accept
    valid = 8'hEF;
    miss(27'h30);
    check("inv_waddr4", r_refill_waddr, 4);
    ptw_accept(1'b1);
    check("req_sf_rdy_state", state_o, 3);
    ptw_if.io_ptw_resp_valid = 1'b1;
    tick();
    ptw_if.io_ptw_resp_valid = 1'b0;
    check("req_sf_rdy_ready", state_o, 0);

    // Flush in REQUEST without PTW accept abandons the walk
    miss(27'h40);
    io_sfence = 1'b1;
    tick();
    io_sfence = 1'b0;
    check("req_sf_state", state_o, 0);
    check("req_sf_ptw_valid", ptw_if.io_ptw_req_valid, 0);

    // Miss together with flush in READY is not accepted; stray response ignored
    io_req_valid = 1'b1; io_req_miss = 1'b1; io_req_bits_vpn = 27'h77; io_sfence = 1'b1;
    tick();
    io_req_valid = 1'b0; io_req_miss = 1'b0; io_sfence = 1'b0;
    check("rdy_sf_state", state_o, 0);
    check("rdy_sf_tag", r_refill_tag, 27'h40);
    ptw_if.io_ptw_resp_valid = 1'b1;
    #1;
    check("rdy_resp_we", refill_we, 0);
    tick();
    ptw_if.io_ptw_resp_valid = 1'b0;
    check("rdy_resp_state", state_o, 0);
    check("rdy_resp_plru", dut.plru, 7'b0111000);

    // Highest way as the only invalid one
    valid = 8'h7F;
    miss(27'h50);
    check("inv_waddr7", r_refill_waddr, 7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
